fetch_unit: RTL and testbench

Instruction-fetch stage that owns the program counter, drives the instruction-memory request/response handshake, and presents one fetched instruction at a time to the decode controller. It is the consumer of the controller's `npc_op` and branch decision: when the core retires the presented instruction, `fetch_unit` computes the next PC from `npc_op`, `br`, `imm` and `jmp_tgt`, then issues the next fetch. It sits between the instruction ROM/bus port and the decode/execute datapath.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_npc.sv | 31 +++
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select encodings,
// fetch FSM states and a small alignment helper.
package fetch_unit_pkg;

    // Next-PC select encodings shared with the decode controller; 2'b11 is unused.
    localparam logic [1:0] NPC_PC4    = 2'b00;
    localparam logic [1:0] NPC_JMP    = 2'b01;
    localparam logic [1:0] NPC_ABSJMP = 2'b10;

    typedef enum logic [1:0] {
        ST_REQ   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_HOLD  = 2'b10,
        ST_FAULT = 2'b11
    } fetch_state_e;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_unit_npc.sv
// Combinational next-PC computation: sequential, conditional relative and
// absolute (bit 0 cleared) targets. All adders wrap modulo 2^32.
module fetch_unit_npc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [1:0]  npc_op_i,
    input  logic        br_i,
    input  logic [31:0] imm_i,
    input  logic [31:0] jmp_tgt_i,
    output logic [31:0] npc_o,
    output logic [31:0] pc4_o
);

    assign pc4_o = pc_i + 32'd4;

    // The undefined encoding falls through to sequential fetch.
    always_comb begin
        npc_o = pc4_o;
        case (npc_op_i)
            NPC_JMP: begin
                if (br_i) begin
                    npc_o = pc_i + imm_i;
                end
            end
            NPC_ABSJMP: npc_o = {jmp_tgt_i[31:1], 1'b0};
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding imem
// request/response handshake and presents one instruction until retired.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic [1:0]  npc_op,
    input  logic        br,
    input  logic [31:0] imm,
    input  logic [31:0] jmp_tgt,
    output logic        fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  npc;

    fetch_unit_npc u_npc (
        .pc_i      (pc_q),
        .npc_op_i  (npc_op),
        .br_i      (br),
        .imm_i     (imm),
        .jmp_tgt_i (jmp_tgt),
        .npc_o     (npc),
        .pc4_o     (pc4)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    // Handshake inputs only matter in the one state that waits on them.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        case (state_q)
            ST_REQ: begin
                if (imem_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    inst_d  = imem_rdata;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    pc_d    = npc;
                    state_d = is_misaligned(npc) ? ST_FAULT : ST_REQ;
                end
            end
            ST_FAULT: ;
            default: state_d = ST_REQ;
        endcase
    end

    assign imem_req    = (state_q == ST_REQ);
    assign imem_addr   = pc_q;
    assign inst        = inst_q;
    assign pc          = pc_q;
    assign inst_valid  = (state_q == ST_HOLD);
    assign fetch_fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// instruction streams checked against a PC-sequence reference model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic        br = 1'b0;
    logic [31:0] imm = '0;
    logic [31:0] jmp_tgt = '0;
    logic        fetch_fault;

    int          compared = 0;
    int          mismatched = 0;
    int          cycleCount = 0;
    logic [31:0] expPc = 32'h0;
    logic        expFault = 1'b0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .pc          (pc),
        .pc4         (pc4),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .npc_op      (npc_op),
        .br          (br),
        .imm         (imm),
        .jmp_tgt     (jmp_tgt),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    // Reference next-PC rule written as plain arithmetic on the retire inputs.
    function automatic logic [31:0] refNextPc(input logic [31:0] cur, input logic [1:0] op,
                                              input logic taken, input logic [31:0] off,
                                              input logic [31:0] tgt);
        if (op == NPC_JMP && taken) return cur + off;
        if (op == NPC_ABSJMP)       return tgt & 32'hFFFF_FFFE;
        return cur + 32'd4;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cycleCount++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drives the handshake inputs; the next-PC inputs get random don't-care values.
    task automatic applyStimulus(input logic gnt, input logic rv, input logic [31:0] rdata, input logic ready);
        imem_gnt    = gnt;
        imem_rvalid = rv;
        imem_rdata  = rdata;
        inst_ready  = ready;
        npc_op      = 2'($urandom_range(0, 3));
        br          = 1'($urandom_range(0, 1));
        imm         = $urandom;
        jmp_tgt     = $urandom;
    endtask

    task automatic doReset;
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
        rst = 1'b1;
        tick;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        expPc    = 32'h0;
        expFault = 1'b0;
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_inst", inst, 32'h0);
        checkOutput("rst_valid", 32'(inst_valid), 32'h0);
        checkOutput("rst_fault", 32'(fetch_fault), 32'h0);
        checkOutput("rst_req", 32'(imem_req), 32'h1);
        checkOutput("rst_addr", imem_addr, 32'h0);
    endtask

    // Carries one instruction from request to retirement with the given stalls.
    task automatic fetchOne(input logic [31:0] word, input int gntDelay, input int rvDelay,
                            input int readyDelay, input logic [1:0] op, input logic brIn,
                            input logic [31:0] immIn, input logic [31:0] tgtIn);
        int          startCycle;
        logic [31:0] nextPc;
        startCycle = cycleCount;
        checkOutput("req_start", 32'(imem_req), 32'h1);
        checkOutput("addr_start", imem_addr, expPc);
        checkOutput("valid_start", 32'(inst_valid), 32'h0);
        for (int i = 0; i < gntDelay; i++) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            tick;
            checkOutput("req_held", 32'(imem_req), 32'h1);
            checkOutput("addr_held", imem_addr, expPc);
            checkOutput("valid_in_req", 32'(inst_valid), 32'h0);
        end
        applyStimulus(1'b1, 1'b0, $urandom, 1'b0);
        tick;
        checkOutput("req_drop", 32'(imem_req), 32'h0);
        checkOutput("valid_in_wait", 32'(inst_valid), 32'h0);
        for (int i = 0; i < rvDelay; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, $urandom, 1'($urandom_range(0, 1)));
            tick;
            checkOutput("no_second_req", 32'(imem_req), 32'h0);
            checkOutput("valid_waiting", 32'(inst_valid), 32'h0);
        end
        applyStimulus(1'b0, 1'b1, word, 1'b0);
        tick;
        checkOutput("valid_hold", 32'(inst_valid), 32'h1);
        checkOutput("inst_data", inst, word);
        checkOutput("pc_hold", pc, expPc);
        checkOutput("pc4_hold", pc4, expPc + 32'd4);
        for (int i = 0; i < readyDelay; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'b0, $urandom, 1'b0);
            tick;
            checkOutput("inst_stable", inst, word);
            checkOutput("valid_stable", 32'(inst_valid), 32'h1);
            checkOutput("req_in_hold", 32'(imem_req), 32'h0);
            checkOutput("addr_stable", imem_addr, expPc);
        end
        applyStimulus(1'b0, 1'b0, $urandom, 1'b1);
        npc_op  = op;
        br      = brIn;
        imm     = immIn;
        jmp_tgt = tgtIn;
        tick;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("cycles_per_inst", 32'(cycleCount - startCycle),
                    32'(3 + gntDelay + rvDelay + readyDelay));
        nextPc   = refNextPc(expPc, op, brIn, immIn, tgtIn);
        expPc    = nextPc;
        expFault = (nextPc % 4) != 0;
        checkOutput("pc_next", pc, nextPc);
        checkOutput("valid_after_retire", 32'(inst_valid), 32'h0);
        checkOutput("fault_after_retire", 32'(fetch_fault), 32'(expFault));
        checkOutput("req_after_retire", 32'(imem_req), 32'(!expFault));
    endtask

    task automatic holdFault(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
            tick;
            checkOutput("fault_sticky", 32'(fetch_fault), 32'h1);
            checkOutput("fault_req", 32'(imem_req), 32'h0);
            checkOutput("fault_valid", 32'(inst_valid), 32'h0);
            checkOutput("fault_pc", pc, expPc);
        end
    endtask

    initial begin
        logic [31:0] rImm;
        logic [31:0] rTgt;

        // Reset and three back-to-back sequential fetches at full rate.
        doReset;
        fetchOne(32'h1111_0001, 0, 0, 0, NPC_PC4, 1'b0, 32'h0, 32'h0);
        checkOutput("seq_addr_4", imem_addr, 32'h4);
        fetchOne(32'h2222_0002, 0, 0, 0, NPC_PC4, 1'b1, 32'h40, 32'h80);
        checkOutput("seq_addr_8", imem_addr, 32'h8);
        fetchOne(32'h3333_0003, 0, 0, 0, NPC_PC4, 1'b0, 32'h0, 32'h0);

        // Taken and not-taken relative branches from 0x100.
        fetchOne(32'h0000_0013, 0, 0, 0, NPC_ABSJMP, 1'b0, 32'h0, 32'h0000_0100);
        fetchOne(32'h0000_0063, 0, 1, 0, NPC_JMP, 1'b1, 32'hFFFF_FFF0, 32'h0);
        checkOutput("br_taken_addr", imem_addr, 32'h0000_00F0);
        fetchOne(32'h0000_0013, 0, 0, 0, NPC_ABSJMP, 1'b0, 32'h0, 32'h0000_0101);
        fetchOne(32'h0000_0063, 0, 0, 0, NPC_JMP, 1'b0, 32'hFFFF_FFF0, 32'h0);
        checkOutput("br_not_taken_addr", imem_addr, 32'h0000_0104);

        // Undefined select encoding behaves as sequential.
        fetchOne(32'hABCD_0000, 0, 0, 0, 2'b11, 1'b1, 32'h100, 32'h4000);
        checkOutput("op11_addr", imem_addr, 32'h0000_0108);

        // Long grant and retire stalls.
        fetchOne(32'hCAFE_F00D, 4, 2, 5, NPC_PC4, 1'b0, 32'h0, 32'h0);

        // Absolute jump to a misaligned target faults and stays faulted.
        fetchOne(32'h0000_006F, 0, 0, 0, NPC_ABSJMP, 1'b0, 32'h0, 32'h0000_2003);
        checkOutput("fault_pc_2002", pc, 32'h0000_2002);
        holdFault(10);

        // Reset mid-fetch with a stale response arriving just after release.
        doReset;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        tick;
        checkOutput("in_wait_req", 32'(imem_req), 32'h0);
        doReset;
        applyStimulus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        tick;
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("stale_valid", 32'(inst_valid), 32'h0);
        checkOutput("stale_inst", inst, 32'h0);
        checkOutput("stale_req", 32'(imem_req), 32'h1);
        checkOutput("stale_addr", imem_addr, 32'h0);
        fetchOne(32'h5555_AAAA, 0, 0, 0, NPC_PC4, 1'b0, 32'h0, 32'h0);

        // Sequential fetch wraps from the top of the address space.
        fetchOne(32'h0000_0067, 0, 0, 0, NPC_ABSJMP, 1'b0, 32'h0, 32'hFFFF_FFFD);
        checkOutput("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetchOne(32'h0000_0013, 0, 0, 0, NPC_PC4, 1'b0, 32'h0, 32'h0);
        checkOutput("wrap_addr", imem_addr, 32'h0);
        checkOutput("wrap_fault", 32'(fetch_fault), 32'h0);

        // Randomized instruction stream with random stalls and next-PC selects.
        for (int n = 0; n < 200; n++) begin
            rImm = $urandom;
            if ($urandom_range(0, 9) != 0) rImm[1:0] = 2'b00;
            rTgt = $urandom;
            if ($urandom_range(0, 9) != 0) rTgt[1] = 1'b0;
            fetchOne($urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rImm, rTgt);
            if (expFault) begin
                holdFault(2);
                doReset;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
